// File: rtl/regfile_pkg.sv
// Shared constants and the byte-merge helper for the multi-port register file.
package regfile_pkg;

    localparam int BYTE          = 8;
    localparam int DEF_WORD      = 16;
    localparam int DEF_REGISTERS = 8;
    localparam int DEF_PC        = 7;

    function automatic logic [BYTE-1:0] merge_byte(
        input logic [BYTE-1:0] cur,
        input logic [BYTE-1:0] wr,
        input logic            en
    );
        return en ? wr : cur;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservations set a bit, committed writes clear it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int REGISTERS = DEF_REGISTERS,
    localparam int AW = $clog2(REGISTERS)
) (
    input  logic                 clk_i,
    input  logic                 srst_n_i,
    input  logic                 rsvEn_i,
    input  logic [AW-1:0]        rsvAddr_i,
    input  logic [REGISTERS-1:0] clr_i,
    output logic [REGISTERS-1:0] busy_o,
    output logic                 rsvErr_o
);

    logic [REGISTERS-1:0] busy_q, busy_d;
    logic                 rsvErr_q, rsvErr_d;

    // Set wins over clear so a new producer keeps the register pending.
    always_comb begin
        busy_d   = busy_q & ~clr_i;
        rsvErr_d = 1'b0;
        if (rsvEn_i) begin
            busy_d[rsvAddr_i] = 1'b1;
            rsvErr_d          = busy_q[rsvAddr_i] & ~clr_i[rsvAddr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            busy_q   <= '0;
            rsvErr_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            rsvErr_q <= rsvErr_d;
        end
    end

    assign busy_o   = busy_q;
    assign rsvErr_o = rsvErr_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with per-byte writes, write forwarding, PC register
// and a reservation scoreboard.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int WORD        = DEF_WORD,
    parameter int REGISTERS   = DEF_REGISTERS,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2,
    parameter int PC          = DEF_PC,
    parameter int BYPASS      = 1,
    localparam int AW = $clog2(REGISTERS),
    localparam int NB = WORD / BYTE
) (
    input  logic                                 clk_i,
    input  logic                                 srst_n_i,
    input  logic [WRITE_PORTS-1:0]               wrEn_i,
    input  logic [WRITE_PORTS-1:0][NB-1:0]       wrMode_i,
    input  logic [WRITE_PORTS-1:0][AW-1:0]       wrAddr_i,
    input  logic [WRITE_PORTS-1:0][WORD-1:0]     data_i,
    input  logic [READ_PORTS-1:0][AW-1:0]        rdAddr_i,
    output logic [READ_PORTS-1:0][WORD-1:0]      data_o,
    output logic [READ_PORTS-1:0]                busy_o,
    input  logic                                 rsvEn_i,
    input  logic [AW-1:0]                        rsvAddr_i,
    input  logic                                 pcEn_i,
    input  logic [WORD-1:0]                      pc_i,
    input  logic                                 pcInc_i,
    output logic [WORD-1:0]                      pc_o,
    output logic                                 conflict_o,
    output logic                                 rsvErr_o
);

    logic [REGISTERS-1:0][WORD-1:0] regs_q, regs_d, wr_nxt;
    logic [REGISTERS-1:0]           wr_hit;
    logic [REGISTERS-1:0]           busy;
    logic                           conflict_q, conflict_d;
    logic                           seen;

    // Ports are visited in ascending order so the highest index wins each byte.
    always_comb begin
        wr_nxt     = regs_q;
        wr_hit     = '0;
        conflict_d = 1'b0;
        seen       = 1'b0;
        for (int r = 0; r < REGISTERS; r++) begin
            for (int b = 0; b < NB; b++) begin
                seen = 1'b0;
                for (int w = 0; w < WRITE_PORTS; w++) begin
                    if (wrEn_i[w] && wrAddr_i[w] == AW'(r)) begin
                        wr_nxt[r][b*BYTE +: BYTE] = merge_byte(wr_nxt[r][b*BYTE +: BYTE],
                                                               data_i[w][b*BYTE +: BYTE],
                                                               wrMode_i[w][b]);
                        if (wrMode_i[w][b]) begin
                            conflict_d = conflict_d | seen;
                            seen       = 1'b1;
                            wr_hit[r]  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // A write port carrying at least one byte enable to PC overrides load/increment.
    always_comb begin
        regs_d = wr_nxt;
        if (!wr_hit[PC]) begin
            if (pcEn_i)
                regs_d[PC] = pc_i;
            else if (pcInc_i)
                regs_d[PC] = regs_q[PC] + WORD'(NB);
        end
    end

    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            data_o[p] = (BYPASS != 0) ? wr_nxt[rdAddr_i[p]] : regs_q[rdAddr_i[p]];
            busy_o[p] = busy[rdAddr_i[p]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            regs_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            conflict_q <= conflict_d;
        end
    end

    assign pc_o       = regs_q[PC];
    assign conflict_o = conflict_q;

    regfile_scoreboard #(
        .REGISTERS(REGISTERS)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .srst_n_i (srst_n_i),
        .rsvEn_i  (rsvEn_i),
        .rsvAddr_i(rsvAddr_i),
        .clr_i    (wr_hit),
        .busy_o   (busy),
        .rsvErr_o (rsvErr_o)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed vector bench for register_file_mp (default parameters, BYPASS=1).
module tb_register_file_mp;

    logic             clk = 1'b0;
    logic             srst_n;
    logic [1:0]       wrEn;
    logic [1:0][1:0]  wrMode;
    logic [1:0][2:0]  wrAddr;
    logic [1:0][15:0] wdata;
    logic [1:0][2:0]  rdAddr;
    logic [1:0][15:0] rdata;
    logic [1:0]       busy;
    logic             rsvEn;
    logic [2:0]       rsvAddr;
    logic             pcEn;
    logic [15:0]      pcIn;
    logic             pcInc;
    logic [15:0]      pcOut;
    logic             conflict;
    logic             rsvErr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_mp dut (
        .clk_i     (clk),
        .srst_n_i  (srst_n),
        .wrEn_i    (wrEn),
        .wrMode_i  (wrMode),
        .wrAddr_i  (wrAddr),
        .data_i    (wdata),
        .rdAddr_i  (rdAddr),
        .data_o    (rdata),
        .busy_o    (busy),
        .rsvEn_i   (rsvEn),
        .rsvAddr_i (rsvAddr),
        .pcEn_i    (pcEn),
        .pc_i      (pcIn),
        .pcInc_i   (pcInc),
        .pc_o      (pcOut),
        .conflict_o(conflict),
        .rsvErr_o  (rsvErr)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic [1:0]  wen;
        logic [1:0]  m0, m1;
        logic [2:0]  a0, a1;
        logic [15:0] d0, d1;
        logic [2:0]  r0, r1;
        logic        rsv;
        logic [2:0]  ra;
        logic        pe;
        logic [15:0] pci;
        logic        pinc;
        logic [15:0] e_d0, e_d1;
        logic [1:0]  e_busy;
        logic [15:0] e_pc;
        logic        e_conf, e_rerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic rst, logic [1:0] wen,
                                logic [1:0] m0, logic [1:0] m1, logic [2:0] a0, logic [2:0] a1,
                                logic [15:0] d0, logic [15:0] d1, logic [2:0] r0, logic [2:0] r1,
                                logic rsv, logic [2:0] ra, logic pe, logic [15:0] pci, logic pinc,
                                logic [15:0] ed0, logic [15:0] ed1, logic [1:0] eb,
                                logic [15:0] epc, logic ec, logic er);
        vec_t v;
        v.name = n; v.rst_n = rst; v.wen = wen; v.m0 = m0; v.m1 = m1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.r0 = r0; v.r1 = r1;
        v.rsv = rsv; v.ra = ra; v.pe = pe; v.pci = pci; v.pinc = pinc;
        v.e_d0 = ed0; v.e_d1 = ed1; v.e_busy = eb; v.e_pc = epc;
        v.e_conf = ec; v.e_rerr = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic idle();
        srst_n = 1'b1;
        wrEn   = '0;
        wrMode = '0;
        wrAddr = '0;
        wdata  = '0;
        rsvEn  = 1'b0;
        rsvAddr = '0;
        pcEn   = 1'b0;
        pcIn   = '0;
        pcInc  = 1'b0;
    endtask

    initial begin
        idle();
        rdAddr = '0;
        //          name        rst wen   m0     m1     a0 a1 d0       d1       r0 r1 rsv ra pe pci      pinc  ed0      ed1      eb     epc      c  e
        vecs.push_back(mk("reset",     0, 2'b11, 2'b11, 2'b11, 3, 4, 16'h1111, 16'h2222, 3, 4, 1, 4, 1, 16'h0055, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0));
        vecs.push_back(mk("wr_r3",     1, 2'b01, 2'b11, 2'b00, 3, 0, 16'h1234, 16'h0000, 3, 0, 0, 0, 0, 16'h0000, 0, 16'h1234, 16'h0000, 2'b00, 16'h0000, 0, 0));
        vecs.push_back(mk("overlap",   1, 2'b11, 2'b11, 2'b01, 2, 2, 16'hAAAA, 16'h5555, 2, 3, 0, 0, 0, 16'h0000, 0, 16'hAA55, 16'h1234, 2'b00, 16'h0000, 1, 0));
        vecs.push_back(mk("idle",      1, 2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 2, 3, 0, 0, 0, 16'h0000, 0, 16'hAA55, 16'h1234, 2'b00, 16'h0000, 0, 0));
        vecs.push_back(mk("wr_pc",     1, 2'b10, 2'b00, 2'b11, 0, 7, 16'h0000, 16'hFFFE, 7, 2, 0, 0, 0, 16'h0000, 0, 16'hFFFE, 16'hAA55, 2'b00, 16'hFFFE, 0, 0));
        vecs.push_back(mk("pc_wrap",   1, 2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 7, 2, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'hAA55, 2'b00, 16'h0000, 0, 0));
        vecs.push_back(mk("pc_prio",   1, 2'b10, 2'b00, 2'b11, 0, 7, 16'h0000, 16'h2222, 7, 2, 0, 0, 1, 16'h0100, 0, 16'h2222, 16'hAA55, 2'b00, 16'h2222, 0, 0));
        vecs.push_back(mk("pc_load",   1, 2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 7, 2, 0, 0, 1, 16'h0100, 1, 16'h0100, 16'hAA55, 2'b00, 16'h0100, 0, 0));
        vecs.push_back(mk("rsv4",      1, 2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 4, 4, 1, 4, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2'b11, 16'h0100, 0, 0));
        vecs.push_back(mk("rsv4_err",  1, 2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 4, 4, 1, 4, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2'b11, 16'h0100, 0, 1));
        vecs.push_back(mk("wr_rsv4",   1, 2'b01, 2'b11, 2'b00, 4, 0, 16'h4444, 16'h0000, 4, 4, 1, 4, 0, 16'h0000, 0, 16'h4444, 16'h4444, 2'b11, 16'h0100, 0, 0));
        vecs.push_back(mk("wr_clr4",   1, 2'b01, 2'b11, 2'b00, 4, 0, 16'h5555, 16'h0000, 4, 4, 0, 0, 0, 16'h0000, 0, 16'h5555, 16'h5555, 2'b00, 16'h0100, 0, 0));
        vecs.push_back(mk("rsv4_b",    1, 2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 4, 4, 1, 4, 0, 16'h0000, 0, 16'h5555, 16'h5555, 2'b11, 16'h0100, 0, 0));
        vecs.push_back(mk("mode0",     1, 2'b11, 2'b00, 2'b00, 4, 4, 16'hFFFF, 16'hFFFF, 4, 4, 0, 0, 0, 16'h0000, 0, 16'h5555, 16'h5555, 2'b11, 16'h0100, 0, 0));
        vecs.push_back(mk("nonovl",    1, 2'b11, 2'b10, 2'b01, 6, 6, 16'hAB00, 16'h00CD, 6, 4, 0, 0, 0, 16'h0000, 0, 16'hABCD, 16'h5555, 2'b10, 16'h0100, 0, 0));
        vecs.push_back(mk("r5_lo",     1, 2'b01, 2'b01, 2'b00, 5, 0, 16'h00FF, 16'h0000, 5, 6, 0, 0, 0, 16'h0000, 0, 16'h00FF, 16'hABCD, 2'b00, 16'h0100, 0, 0));
        vecs.push_back(mk("r5_hi",     1, 2'b01, 2'b10, 2'b00, 5, 0, 16'hAB00, 16'h0000, 5, 6, 0, 0, 0, 16'h0000, 0, 16'hABFF, 16'hABCD, 2'b00, 16'h0100, 0, 0));
        vecs.push_back(mk("rsv5",      1, 2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 5, 6, 1, 5, 0, 16'h0000, 0, 16'hABFF, 16'hABCD, 2'b01, 16'h0100, 0, 0));
        vecs.push_back(mk("rsv5_err",  1, 2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 5, 6, 1, 5, 0, 16'h0000, 0, 16'hABFF, 16'hABCD, 2'b01, 16'h0100, 0, 1));
        vecs.push_back(mk("rst_mid",   0, 2'b01, 2'b11, 2'b00, 5, 0, 16'h1111, 16'h0000, 5, 6, 1, 5, 1, 16'h7777, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0));
        vecs.push_back(mk("post_rst",  1, 2'b00, 2'b00, 2'b00, 0, 0, 16'h0000, 16'h0000, 1, 5, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2'b01, 16'h0000, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            srst_n    = vecs[i].rst_n;
            wrEn      = vecs[i].wen;
            wrMode[0] = vecs[i].m0;
            wrMode[1] = vecs[i].m1;
            wrAddr[0] = vecs[i].a0;
            wrAddr[1] = vecs[i].a1;
            wdata[0]  = vecs[i].d0;
            wdata[1]  = vecs[i].d1;
            rdAddr[0] = vecs[i].r0;
            rdAddr[1] = vecs[i].r1;
            rsvEn     = vecs[i].rsv;
            rsvAddr   = vecs[i].ra;
            pcEn      = vecs[i].pe;
            pcIn      = vecs[i].pci;
            pcInc     = vecs[i].pinc;
            @(posedge clk);
            #1 idle();
            #1;
            check({vecs[i].name, ".data0"},    rdata[0],          vecs[i].e_d0);
            check({vecs[i].name, ".data1"},    rdata[1],          vecs[i].e_d1);
            check({vecs[i].name, ".busy"},     {14'd0, busy},     {14'd0, vecs[i].e_busy});
            check({vecs[i].name, ".pc"},       pcOut,             vecs[i].e_pc);
            check({vecs[i].name, ".conflict"}, {15'd0, conflict}, {15'd0, vecs[i].e_conf});
            check({vecs[i].name, ".rsvErr"},   {15'd0, rsvErr},   {15'd0, vecs[i].e_rerr});
        end

        // Same-cycle forwarding of a write; PC increment must not be forwarded.
        @(negedge clk);
        wrEn = 2'b01; wrMode[0] = 2'b11; wrAddr[0] = 3'd1; wdata[0] = 16'hBEEF;
        pcInc = 1'b1; rdAddr[0] = 3'd1; rdAddr[1] = 3'd7;
        #1;
        check("byp_write", rdata[0], 16'hBEEF);
        check("byp_pc_not_fwd", rdata[1], 16'h0000);
        @(posedge clk);
        #1 idle();
        #1;
        check("byp_pc_after", pcOut, 16'h0002);
        check("byp_busy_clr", {15'd0, busy[0]}, 16'h0000);
        check("byp_r1_after", rdata[0], 16'hBEEF);

        // Forwarding with per-byte priority, then the conflict pulse after the edge.
        @(negedge clk);
        wrEn = 2'b11;
        wrMode[0] = 2'b11; wrAddr[0] = 3'd2; wdata[0] = 16'hAAAA;
        wrMode[1] = 2'b01; wrAddr[1] = 3'd2; wdata[1] = 16'h5555;
        rdAddr[0] = 3'd2; rdAddr[1] = 3'd2;
        #1;
        check("byp_merge", rdata[0], 16'hAA55);
        check("byp_conf_pre", {15'd0, conflict}, 16'h0000);
        @(posedge clk);
        #1 idle();
        #1;
        check("byp_conf_post", {15'd0, conflict}, 16'h0001);
        @(posedge clk);
        #1;
        check("byp_conf_drop", {15'd0, conflict}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
